// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bundle for the bit-serial subtractor.
// The controller side takes the master modport and the subtractor takes the slave modport.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one full-subtractor step per clock with a registered borrow.
// The result and borrow registers update only when the last bit completes, so partial sums never show.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  serial_subtractor_if.slave bus
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] r_reg, r_next;
  logic             br_reg, br_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [WIDTH-1:0] diff_reg, diff_next;
  logic             bout_reg, bout_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic             x;
  logic             y;
  logic             d;
  logic             br_calc;
  logic [WIDTH-1:0] r_shift;

  // Full-subtractor cell on the current LSBs.
  assign x       = a_reg[0];
  assign y       = b_reg[0];
  assign d       = x ^ y ^ br_reg;
  assign br_calc = (~x & y) | (~(x ^ y) & br_reg);

  generate
    if (WIDTH == 1) begin : g_r_single
      assign r_shift = d;
    end else begin : g_r_multi
      assign r_shift = {d, r_reg[WIDTH-1:1]};
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    r_next     = r_reg;
    br_next    = br_reg;
    cnt_next   = cnt_reg;
    diff_next  = diff_reg;
    bout_next  = bout_reg;

    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          state_next = RUN;
          a_next     = bus.a;
          b_next     = bus.b;
          br_next    = bus.bin;
          cnt_next   = '0;
        end
      end

      RUN: begin
        a_next   = a_reg >> 1;
        b_next   = b_reg >> 1;
        r_next   = r_shift;
        br_next  = br_calc;
        cnt_next = cnt_reg + 1'b1;
        if (cnt_reg == LAST) begin
          state_next = DONE;
          diff_next  = r_shift;
          bout_next  = br_calc;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase

    // Status flags are registered copies of the next-state decode.
    busy_next = (state_next != IDLE);
    done_next = (state_next == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      b_reg     <= '0;
      r_reg     <= '0;
      br_reg    <= 1'b0;
      cnt_reg   <= '0;
      diff_reg  <= '0;
      bout_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      a_reg     <= a_next;
      b_reg     <= b_next;
      r_reg     <= r_next;
      br_reg    <= br_next;
      cnt_reg   <= cnt_next;
      diff_reg  <= diff_next;
      bout_reg  <= bout_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;

endmodule
